// File: rtl/pipe_chain.sv
// N-stage valid/allowin pipeline skeleton: per-stage bus and valid registers,
// combinational allowin chain, ranged flush, stall counter and occupancy.
module pipe_chain #(
    parameter int STAGES = 5,
    parameter int DATA_W = 64,
    parameter int FW     = $clog2(STAGES),
    parameter int OW     = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_allowin,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [STAGES*DATA_W-1:0] xform_data,
    input  logic [STAGES-1:0]        stage_ready_go,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     flush_valid,
    input  logic [FW-1:0]            flush_upto,
    output logic [OW-1:0]            occupancy,
    output logic [31:0]              stall_cnt
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [31:0]       stall_q, stall_d;

    logic [STAGES-1:0] killed, ev, to_next, src_valid;
    logic [STAGES:0]   allowin;
    logic [DATA_W-1:0] src_data [STAGES];

    // Slice 0 of xform_data has no consumer; stage 0 is fed from in_data.
    logic unused_xform0;
    assign unused_xform0 = ^xform_data[DATA_W-1:0];

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        killed    = '0;
        ev        = '0;
        to_next   = '0;
        allowin   = '0;
        src_valid = '0;
        valid_d   = valid_q;
        for (int k = 0; k < STAGES; k++) begin
            src_data[k] = '0;
            data_d[k]   = data_q[k];
        end

        for (int k = 0; k < STAGES; k++) begin
            killed[k]  = flush_valid && (k <= int'(flush_upto));
            ev[k]      = valid_q[k] && !killed[k];
            to_next[k] = ev[k] && stage_ready_go[k];
        end

        // Backpressure ripples from the sink back to stage 0 in one cycle.
        allowin[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            allowin[k] = !ev[k] || (stage_ready_go[k] && allowin[k+1]);
        end

        in_allowin = allowin[0] && !flush_valid;
        out_valid  = to_next[STAGES-1];

        src_valid[0] = in_valid && in_allowin;
        src_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = to_next[k-1];
            src_data[k]  = xform_data[k*DATA_W +: DATA_W];
        end

        for (int k = 0; k < STAGES; k++) begin
            if (killed[k]) begin
                valid_d[k] = 1'b0;
            end else if (allowin[k]) begin
                valid_d[k] = src_valid[k];
            end
            if (src_valid[k] && allowin[k] && !killed[k]) begin
                data_d[k] = src_data[k];
            end
        end

        stall_d = stall_q + 32'(in_valid && !in_allowin);
    end

    // NOTE: state registers use non-blocking assignments so all stages update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            stall_q <= '0;
            // NOTE: the bus registers are cleared too, so stage_data reads zero after reset.
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            stall_q <= stall_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    always_comb begin
        stage_data = '0;
        occupancy  = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_data[k*DATA_W +: DATA_W] = data_q[k];
            occupancy = occupancy + OW'(valid_q[k]);
        end
    end

    assign stage_valid = valid_q;
    assign out_data    = data_q[STAGES-1];
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (STAGES=5, DATA_W=64); stage k's transform
// adds 0x100 to the previous stage's bus, so stage k data = source + k*0x100.
module tb_pipe_chain;

    localparam int STAGES = 5;
    localparam int DATA_W = 64;
    localparam int FW     = $clog2(STAGES);
    localparam int OW     = $clog2(STAGES + 1);

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_allowin;
    logic [DATA_W-1:0]        in_data;
    logic [STAGES*DATA_W-1:0] xform_data;
    logic [STAGES-1:0]        stage_ready_go;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     flush_valid;
    logic [FW-1:0]            flush_upto;
    logic [OW-1:0]            occupancy;
    logic [31:0]              stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_chain #(.STAGES(STAGES), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_allowin     (in_allowin),
        .in_data        (in_data),
        .xform_data     (xform_data),
        .stage_ready_go (stage_ready_go),
        .stage_valid    (stage_valid),
        .stage_data     (stage_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .flush_valid    (flush_valid),
        .flush_upto     (flush_upto),
        .occupancy      (occupancy),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        xform_data = '0;
        for (int k = 1; k < STAGES; k++) begin
            xform_data[k*DATA_W +: DATA_W] = stage_data[(k-1)*DATA_W +: DATA_W] + 64'h100;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sd(input int k);
        return stage_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill5(input logic [63:0] base);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = base + 64'(i);
            tick();
        end
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_data        = '0;
        stage_ready_go = '1;
        out_ready      = 1'b1;
        flush_valid    = 1'b0;
        flush_upto     = '0;
        tick();
        tick();

        // Reset state
        reset = 1'b0;
        #1;
        check("rst_valid", stage_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_allowin", in_allowin, 1);
        check("rst_data4", sd(4), 0);

        // Stream 0x1..0x8 through a free-running pipe
        for (int c = 0; c < 14; c++) begin
            int acc;
            int left;
            logic exp_ov;
            in_valid = (c < 8);
            in_data  = 64'(c + 1);
            #1;
            acc    = (c < 8) ? c : 8;
            left   = (c < 5) ? 0 : ((c - 5 > 8) ? 8 : c - 5);
            exp_ov = (c >= 5) && (c < 13);
            check("p1_allowin", in_allowin, 1);
            check("p1_out_valid", out_valid, 64'(exp_ov));
            if (exp_ov) check("p1_out_data", out_data, 64'(c - 4) + 64'h400);
            check("p1_occ", occupancy, 64'(acc - left));
            if (c == 7) begin
                for (int k = 0; k < STAGES; k++) begin
                    check("p1_stage_data", sd(k), 64'(7 - k) + 64'(k) * 64'h100);
                end
            end
            tick();
        end

        // Stall stage 2 for three cycles on a full pipe with continuous input
        fill5(64'h11);
        stage_ready_go = 5'b11011;
        in_valid       = 1'b1;
        in_data        = 64'h16;
        #1;
        check("st0_allowin", in_allowin, 0);
        check("st0_out_valid", out_valid, 1);
        check("st0_out_data", out_data, 64'h411);
        check("st0_occ", occupancy, 5);
        tick();
        check("st1_valid", stage_valid, 5'b10111);
        check("st1_occ", occupancy, 4);
        check("st1_out_data", out_data, 64'h412);
        check("st1_allowin", in_allowin, 0);
        tick();
        check("st2_valid", stage_valid, 5'b00111);
        check("st2_out_valid", out_valid, 0);
        check("st2_allowin", in_allowin, 0);
        tick();
        stage_ready_go = '1;
        in_valid       = 1'b0;
        #1;
        check("st3_stall_cnt", stall_cnt, 3);
        check("st3_valid", stage_valid, 5'b00111);
        check("st3_data2", sd(2), 64'h213);
        check("st3_data0", sd(0), 64'h15);
        check("st3_allowin", in_allowin, 1);
        repeat (6) tick();
        check("st_drained", occupancy, 0);

        // Partial flush of stages 0..1 on a full pipe
        fill5(64'h21);
        in_valid    = 1'b1;
        in_data     = 64'h26;
        flush_valid = 1'b1;
        flush_upto  = 3'd1;
        #1;
        check("fl1_allowin", in_allowin, 0);
        check("fl1_out_valid", out_valid, 1);
        check("fl1_out_data", out_data, 64'h421);
        tick();
        flush_valid = 1'b0;
        in_valid    = 1'b0;
        #1;
        check("fl1_valid", stage_valid, 5'b11000);
        check("fl1_stall_cnt", stall_cnt, 4);
        check("fl1_data3", sd(3), 64'h323);
        check("fl1_out_data_next", out_data, 64'h422);
        tick();
        tick();
        check("fl1_drained", occupancy, 0);

        // Full flush with an out-of-range flush_upto
        fill5(64'h31);
        in_valid    = 1'b0;
        flush_valid = 1'b1;
        flush_upto  = 3'd7;
        #1;
        check("flA_pre_valid", stage_valid, 5'b11111);
        check("flA_out_valid", out_valid, 0);
        check("flA_allowin", in_allowin, 0);
        tick();
        flush_valid = 1'b0;
        #1;
        check("flA_valid", stage_valid, 0);
        check("flA_occ", occupancy, 0);
        check("flA_stall_cnt", stall_cnt, 4);

        // Sink blocked for ten cycles with a continuous stream
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 64'h41 + 64'(c);
            #1;
            check("bp_allowin", in_allowin, 64'(c < 5));
            if (c == 9) begin
                check("bp_occ", occupancy, 5);
                check("bp_out_valid", out_valid, 1);
                check("bp_out_data", out_data, 64'h441);
                check("bp_data0", sd(0), 64'h45);
                check("bp_data1", sd(1), 64'h144);
                check("bp_data2", sd(2), 64'h243);
                check("bp_data3", sd(3), 64'h342);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("bp_stall_cnt", stall_cnt, 9);
        check("bp_occ_hold", occupancy, 5);

        // Reset while full and during a flush, then a single bus end-to-end
        reset       = 1'b1;
        flush_valid = 1'b1;
        flush_upto  = 3'd1;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        reset       = 1'b0;
        flush_valid = 1'b0;
        in_valid    = 1'b1;
        in_data     = 64'h55;
        #1;
        check("rr_valid", stage_valid, 0);
        check("rr_stall_cnt", stall_cnt, 0);
        check("rr_occ", occupancy, 0);
        check("rr_data4", sd(4), 0);
        check("rr_allowin", in_allowin, 1);
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            #1;
            if (n < 5) begin
                check("rr_walk_valid", stage_valid, 64'(1) << (n - 1));
                check("rr_walk_out_valid", out_valid, 0);
            end else begin
                check("rr_emerge_valid", stage_valid, 5'b10000);
                check("rr_emerge_out_valid", out_valid, 1);
                check("rr_emerge_data", out_data, 64'h455);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised N-stage valid/allowin pipeline skeleton that generalises the five-stage fs/ds/es/ms/ws handshake chain of the CPU top. It holds one DATA_W-bit bus register and one valid bit per stage, computes the combinational allowin chain, and accepts per-stage ready_go (stall) inputs. It adds what the fixed chain lacks: a ranged flush for branch and exception cancel, a stall counter and an occupancy output. Per-stage datapath logic sits outside the block and feeds each stage's next bus through xform_data.

## Interface
- STAGES, 5, number of pipeline stages, 2..8
- DATA_W, 64, width of every stage bus
- FW, $clog2(STAGES), width of flush_upto
- OW, $clog2(STAGES+1), width of occupancy
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- in_valid  input  1  upstream (fetch) has a bus to insert
- in_allowin  output  1  stage 0 accepts this cycle
- in_data  input  DATA_W  bus captured into stage 0
- xform_data  input  STAGES*DATA_W  slice k (k≥1) is the bus captured into stage k; slice 0 is ignored
- stage_ready_go  input  STAGES  bit k: stage k has finished its work
- stage_valid  output  STAGES  raw valid registers
- stage_data  output  STAGES*DATA_W  bus registers, slice k = stage k
- out_valid  output  1  last stage presents a finished bus
- out_ready  input  1  sink accepts (allowin beyond last stage)
- out_data  output  DATA_W  equals stage_data slice STAGES-1
- flush_valid  input  1  cancel request this cycle
- flush_upto  input  FW  stages 0..flush_upto are cancelled; values ≥STAGES-1 mean all stages
- occupancy  output  OW  popcount of stage_valid
- stall_cnt  output  32  cycles with in_valid=1 and in_allowin=0

## Operation
- killed[k] = flush_valid && k ≤ min(flush_upto, STAGES-1); ev[k] = valid[k] && !killed[k].
- to_next[k] = ev[k] && stage_ready_go[k].
- allowin[STAGES] = out_ready; allowin[k] = !ev[k] || (stage_ready_go[k] && allowin[k+1]).
- in_allowin = allowin[0] && !flush_valid. out_valid = to_next[STAGES-1].
- Stage 0 source valid = in_valid && in_allowin, data = in_data. Stage k≥1 source valid = to_next[k-1], data = xform_data slice k.
- At each edge: killed stage → valid<=0; otherwise, if allowin[k] → valid<=source valid; else hold. Data loads only when source valid && allowin[k] && !killed[k]; otherwise data holds.
- Stage flush_upto+1 receives nothing in the flush cycle, because its source is killed; it keeps or drains its own content normally.
- Bubbles: a stage whose successor is empty advances even while later stages stall. No skid buffering; throughput is 1 bus/cycle when all ready_go=1 and out_ready=1.
- stall_cnt increments by 1 per qualifying cycle and wraps at 2^32. occupancy is computed from registers.

## Timing
- Reset: all valid=0, all stage_data=0, stall_cnt=0, occupancy=0, out_valid=0. in_allowin=1 in the first post-reset cycle unless flush_valid is high.
- Reset asserted mid-operation overrides flush and transfers on that edge.
- Latency: a bus accepted at edge t sits in stage k after edge t+k. out_valid is high during the cycle after edge t+STAGES-1 when all ready_go are high.
- in_allowin, out_valid and allowin are combinational from registers, stage_ready_go, out_ready and flush. The allowin path spans all stages; there is no registered backpressure.
- Flush takes effect in the same cycle: killed stages neither hand off nor count toward allowin. A full flush with out_ready=1 produces no out_valid that cycle.
- Simultaneous insert and full-pipe drain: a full pipe with all ready accepts a new bus and emits one every cycle.

## Test plan
- After reset, insert 0x1..0x8 with ready_go=all-1 and out_ready=1, STAGES=5 → out_data 0x1 with out_valid one cycle after stage-4 load (4 edges after accept); then one bus per cycle; occupancy settles at 5.
- Hold stage_ready_go[2]=0 for 3 cycles with a continuous stream → stages 0–2 hold, stages 3–4 drain to occupancy 3; in_allowin=0; stall_cnt increases by 3 (or more while in_valid remains high).
- Pipe full, flush_valid=1, flush_upto=1 → stages 0,1 become invalid; stage 2 becomes invalid if it advanced; stages 3,4 continue; in_allowin=0 that cycle.
- flush_upto=7 with STAGES=5 and out_ready=1 → all valid=0 next cycle, out_valid=0 during the flush cycle, occupancy=0.
- out_ready=0 for 10 cycles with a stream → pipe fills to occupancy 5, and stage data stays unchanged while out_valid=1 is held.
- Reset pulsed while full and during a flush → all valid=0, stall_cnt=0; a bus inserted the next cycle emerges after STAGES-1 further edges.
